// File: rtl/vga_timing_ctrl_if.sv
// vga_if: pin bundle between the VGA timing controller and the board DAC.
interface vga_if;
    logic       VGA_CLK;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK;
    logic       VGA_SYNC;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;

    modport master (output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_R, VGA_G, VGA_B);
    modport slave  (input  VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_R, VGA_G, VGA_B);
endinterface

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster timing, sync/blank generation and pixel pull from a valid/ready stream.
// Optional macro VGA_TESTPATTERN_EN adds test_mode, which replaces the stream with 8 colour bars.
module vga_timing_ctrl #(
    parameter int HDISP  = 800,
    parameter int HFP    = 40,
    parameter int HPULSE = 128,
    parameter int HBP    = 88,
    parameter int VDISP  = 480,
    parameter int VFP    = 1,
    parameter int VPULSE = 3,
    parameter int VBP    = 21
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst,
    input  logic        enable,
`ifdef VGA_TESTPATTERN_EN
    input  logic        test_mode,
`endif
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        frame_start,
    output logic        underflow,
    output logic [15:0] underflow_cnt,
    vga_if.master       vga_ifm
);
    localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
    localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);

    localparam logic [HW-1:0] H_DISP   = HW'(HDISP);
    localparam logic [HW-1:0] H_SYNC_S = HW'(HDISP + HFP);
    localparam logic [HW-1:0] H_SYNC_E = HW'(HDISP + HFP + HPULSE);
    localparam logic [HW-1:0] H_LAST   = HW'(HTOTAL - 1);
    localparam logic [VW-1:0] V_DISP   = VW'(VDISP);
    localparam logic [VW-1:0] V_SYNC_S = VW'(VDISP + VFP);
    localparam logic [VW-1:0] V_SYNC_E = VW'(VDISP + VFP + VPULSE);
    localparam logic [VW-1:0] V_LAST   = VW'(VTOTAL - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        r_state;
    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic          r_hs;
    logic          r_vs;
    logic          r_blank;
    logic [23:0]   r_rgb;
    logic          r_frame_start;
    logic          r_underflow;
    logic [15:0]   r_underflow_cnt;

    logic          w_run;
    logic          w_active;
    logic          w_ready;
    logic          w_consume;
    logic          w_missing;
    logic          w_hs_pulse;
    logic          w_vs_pulse;
    logic [23:0]   w_rgb;

    assign w_run      = (r_state == RUN);
    assign w_active   = w_run && (r_h < H_DISP) && (r_v < V_DISP);
    assign w_hs_pulse = w_run && (r_h >= H_SYNC_S) && (r_h < H_SYNC_E);
    assign w_vs_pulse = w_run && (r_v >= V_SYNC_S) && (r_v < V_SYNC_E);
    assign w_consume  = w_ready && pix_valid;
    assign w_missing  = w_ready && !pix_valid;

`ifdef VGA_TESTPATTERN_EN
    // Bar index bits map directly to colour: R=~b[1], G=~b[2], B=~b[0] gives W,Y,C,G,M,R,B,K.
    localparam int BAR_W = HDISP / 8;
    logic [2:0] w_bar;
    assign w_bar   = 3'(r_h / HW'(BAR_W));
    assign w_ready = w_active && !test_mode;
    assign w_rgb   = (test_mode && w_active) ? {{8{~w_bar[1]}}, {8{~w_bar[2]}}, {8{~w_bar[0]}}}
                   : (w_consume ? pix_data : 24'h0);
`else
    assign w_ready = w_active;
    assign w_rgb   = w_consume ? pix_data : 24'h0;
`endif

    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            r_state         <= IDLE;
            r_h             <= '0;
            r_v             <= '0;
            r_hs            <= 1'b1;
            r_vs            <= 1'b1;
            r_blank         <= 1'b0;
            r_rgb           <= 24'h0;
            r_frame_start   <= 1'b0;
            r_underflow     <= 1'b0;
            r_underflow_cnt <= 16'h0;
        end else begin
            // Pins lag the counters by one cycle, so every output is derived from the current h/v.
            r_hs          <= ~w_hs_pulse;
            r_vs          <= ~w_vs_pulse;
            r_blank       <= w_active;
            r_rgb         <= w_rgb;
            r_frame_start <= w_run && (r_h == '0) && (r_v == '0);
            if (w_missing) begin
                r_underflow <= 1'b1;
                if (r_underflow_cnt != 16'hFFFF) begin
                    r_underflow_cnt <= r_underflow_cnt + 16'd1;
                end
            end
            case (r_state)
                IDLE: begin
                    r_h <= '0;
                    r_v <= '0;
                    if (enable) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (r_h == H_LAST) begin
                        r_h <= '0;
                        if (r_v == V_LAST) begin
                            r_v <= '0;
                            // Stopping only on the frame boundary keeps the monitor from seeing a torn frame.
                            if (!enable) begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_v <= r_v + VW'(1);
                        end
                    end else begin
                        r_h <= r_h + HW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign pix_ready     = w_ready;
    assign frame_start   = r_frame_start;
    assign underflow     = r_underflow;
    assign underflow_cnt = r_underflow_cnt;

    assign vga_ifm.VGA_CLK   = ~pixel_clk;
    assign vga_ifm.VGA_HS    = r_hs;
    assign vga_ifm.VGA_VS    = r_vs;
    assign vga_ifm.VGA_BLANK = r_blank;
    assign vga_ifm.VGA_SYNC  = 1'b0;
    assign vga_ifm.VGA_R     = r_rgb[23:16];
    assign vga_ifm.VGA_G     = r_rgb[15:8];
    assign vga_ifm.VGA_B     = r_rgb[7:0];
endmodule
